// File: rtl/hangman_engine_param_if.sv
// Guess/word handshake and status bundle between the input decoder,
// the hangman engine and the status output packer.
interface hangman_engine_param_if #(
  parameter int WORD_LEN   = 5,
  parameter int LETTER_W   = 5,
  parameter int MAX_MISSES = 7
);
  localparam int MISS_W = $clog2(MAX_MISSES + 1);

  logic                         word_load;
  logic [WORD_LEN*LETTER_W-1:0] word_in;
  logic                         guess_valid;
  logic [LETTER_W-1:0]          guess_letter;
  logic                         busy;
  logic [WORD_LEN-1:0]          found_mask;
  logic [MISS_W-1:0]            miss_count;
  logic                         win;
  logic                         lose;
  logic                         repeat_hit;

  // Decoder side: supplies word and guesses, observes game status.
  modport master (
    output word_load, word_in, guess_valid, guess_letter,
    input  busy, found_mask, miss_count, win, lose, repeat_hit
  );

  // Engine side.
  modport slave (
    input  word_load, word_in, guess_valid, guess_letter,
    output busy, found_mask, miss_count, win, lose, repeat_hit
  );
endinterface

// File: rtl/hangman_engine_param.sv
// Hangman game engine: holds a WORD_LEN-letter secret word, scans each
// guess against one position per clock, reveals every matching position
// and tracks misses up to MAX_MISSES.
module hangman_engine_param #(
  parameter int WORD_LEN   = 5,
  parameter int LETTER_W   = 5,
  parameter int MAX_MISSES = 7,
  parameter int MISS_W     = $clog2(MAX_MISSES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  hangman_engine_param_if.slave bus
);

  localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    SCAN = 3'd2,
    EVAL = 3'd3,
    WIN  = 3'd4,
    LOSE = 3'd5
  } state_t;

  state_t              state_reg;
  logic [LETTER_W-1:0] word_reg [WORD_LEN];
  logic [LETTER_W-1:0] letter_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic                hit_reg;
  logic                new_reg;
  logic                busy_reg;
  logic [WORD_LEN-1:0] found_pos_reg;  // bit i = position i revealed
  logic [MISS_W-1:0]   miss_reg;
  logic                win_reg;
  logic                lose_reg;
  logic                repeat_hit_reg;

  logic                load_word;
  logic                cur_match;
  logic                last_idx;
  logic [MISS_W-1:0]   miss_next;

  // A new word is accepted only from IDLE or from a finished game.
  assign load_word = bus.word_load &&
                     (state_reg == IDLE || state_reg == WIN || state_reg == LOSE);
  assign cur_match = (word_reg[idx_reg] == letter_reg);
  assign last_idx  = (idx_reg == IDX_W'(WORD_LEN - 1));
  // Miss counter saturates so it can never wrap past the limit.
  assign miss_next = (miss_reg == MISS_W'(MAX_MISSES)) ? miss_reg
                                                       : miss_reg + 1'b1;

  // Secret word register; position 0 is the most significant slice of word_in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORD_LEN; i++) word_reg[i] <= '0;
    end else if (load_word) begin
      for (int i = 0; i < WORD_LEN; i++)
        word_reg[i] <= bus.word_in[(WORD_LEN-1-i)*LETTER_W +: LETTER_W];
    end
  end

  // Game FSM with all status outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      letter_reg     <= '0;
      idx_reg        <= '0;
      hit_reg        <= 1'b0;
      new_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      found_pos_reg  <= '0;
      miss_reg       <= '0;
      win_reg        <= 1'b0;
      lose_reg       <= 1'b0;
      repeat_hit_reg <= 1'b0;
    end else begin
      repeat_hit_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.word_load) begin
            found_pos_reg <= '0;
            miss_reg      <= '0;
            state_reg     <= PLAY;
          end
        end
        PLAY: begin
          // A guess wins over a simultaneous word_load, which is dropped.
          if (bus.guess_valid) begin
            letter_reg <= bus.guess_letter;
            idx_reg    <= '0;
            hit_reg    <= 1'b0;
            new_reg    <= 1'b0;
            busy_reg   <= 1'b1;
            state_reg  <= SCAN;
          end
        end
        SCAN: begin
          if (cur_match) begin
            found_pos_reg[idx_reg] <= 1'b1;
            hit_reg                <= 1'b1;
            if (!found_pos_reg[idx_reg]) new_reg <= 1'b1;
          end
          if (last_idx) state_reg <= EVAL;
          else          idx_reg   <= idx_reg + 1'b1;
        end
        EVAL: begin
          busy_reg <= 1'b0;
          if (!hit_reg) miss_reg <= miss_next;
          if (hit_reg && !new_reg) repeat_hit_reg <= 1'b1;
          if (&found_pos_reg) begin
            win_reg   <= 1'b1;
            state_reg <= WIN;
          end else if (!hit_reg && miss_next == MISS_W'(MAX_MISSES)) begin
            lose_reg  <= 1'b1;
            state_reg <= LOSE;
          end else begin
            state_reg <= PLAY;
          end
        end
        WIN, LOSE: begin
          // Restart with a new word takes priority over returning to IDLE.
          if (bus.word_load) begin
            found_pos_reg <= '0;
            miss_reg      <= '0;
            win_reg       <= 1'b0;
            lose_reg      <= 1'b0;
            state_reg     <= PLAY;
          end else if (bus.guess_valid) begin
            found_pos_reg <= '0;
            miss_reg      <= '0;
            win_reg       <= 1'b0;
            lose_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // found_mask is presented MSB-first: position i drives bit WORD_LEN-1-i.
  for (genvar gi = 0; gi < WORD_LEN; gi++) begin : g_mask
    assign bus.found_mask[WORD_LEN-1-gi] = found_pos_reg[gi];
  end

  assign bus.busy       = busy_reg;
  assign bus.miss_count = miss_reg;
  assign bus.win        = win_reg;
  assign bus.lose       = lose_reg;
  assign bus.repeat_hit = repeat_hit_reg;

endmodule

// File: tb/tb_hangman_engine_param.sv
// Directed bench for hangman_engine_param: a default 5-letter instance and
// an 8-letter / 3-miss instance, with hand-computed expected status.
module tb_hangman_engine_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   edges;

  always #5 clk = ~clk;

  hangman_engine_param_if #(.WORD_LEN(5), .LETTER_W(5), .MAX_MISSES(7)) aif ();
  hangman_engine_param_if #(.WORD_LEN(8), .LETTER_W(5), .MAX_MISSES(3)) bif ();

  hangman_engine_param #(.WORD_LEN(5), .LETTER_W(5), .MAX_MISSES(7)) dut_a (
    .clk(clk), .reset(reset), .bus(aif.slave));
  hangman_engine_param #(.WORD_LEN(8), .LETTER_W(5), .MAX_MISSES(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bif.slave));

  // Letter codes: a=0 ... z=25.
  localparam logic [4:0] L_A = 5'd0,  L_E = 5'd4,  L_F = 5'd5,  L_I = 5'd8;
  localparam logic [4:0] L_N = 5'd13, L_O = 5'd14, L_R = 5'd17, L_S = 5'd18;
  localparam logic [4:0] L_T = 5'd19;
  localparam logic [39:0] W_NOTRE    = {15'd0, L_N, L_O, L_T, L_R, L_E};
  localparam logic [39:0] W_EERIE    = {15'd0, L_E, L_E, L_R, L_I, L_E};
  localparam logic [39:0] W_AAAAA    = 40'd0;
  localparam logic [39:0] W_REFEREES = {L_R, L_E, L_F, L_E, L_R, L_E, L_E, L_S};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Pulse word_load for one edge on the selected instance.
  task automatic do_load(input bit b, input logic [39:0] w);
    @(negedge clk);
    if (b) begin bif.word_load = 1'b1; bif.word_in = w; end
    else   begin aif.word_load = 1'b1; aif.word_in = w[24:0]; end
    @(posedge clk); #1;
    aif.word_load = 1'b0;
    bif.word_load = 1'b0;
  endtask

  // Present one guess, then wait (bounded) until busy is low again.
  // n_edges counts clock edges from the accept edge inclusive.
  task automatic do_guess(input bit b, input logic [4:0] l, output int n_edges);
    @(negedge clk);
    if (b) begin bif.guess_valid = 1'b1; bif.guess_letter = l; end
    else   begin aif.guess_valid = 1'b1; aif.guess_letter = l; end
    @(posedge clk); #1;
    n_edges = 1;
    aif.guess_valid = 1'b0;
    bif.guess_valid = 1'b0;
    aif.word_load   = 1'b0;
    while (n_edges < 40) begin
      @(posedge clk); #1;
      n_edges++;
      if (b ? !bif.busy : !aif.busy) break;
    end
    if (n_edges >= 40) check("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    aif.word_load = 0; aif.word_in = '0; aif.guess_valid = 0; aif.guess_letter = '0;
    bif.word_load = 0; bif.word_in = '0; bif.guess_valid = 0; bif.guess_letter = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mask", 32'(aif.found_mask), 32'd0);
    check("rst_busy", 32'(aif.busy), 32'd0);
    check("rst_miss", 32'(aif.miss_count), 32'd0);
    check("rst_winlose", 32'({aif.win, aif.lose, aif.repeat_hit}), 32'd0);
    @(negedge clk) reset = 1'b1;

    // 1: notre, reveal letter by letter, win timing.
    do_load(0, W_NOTRE);
    do_guess(0, L_N, edges); check("s1_mask_n", 32'(aif.found_mask), 32'b10000);
    do_guess(0, L_O, edges); check("s1_mask_o", 32'(aif.found_mask), 32'b11000);
    do_guess(0, L_T, edges); check("s1_mask_t", 32'(aif.found_mask), 32'b11100);
    do_guess(0, L_R, edges); check("s1_mask_r", 32'(aif.found_mask), 32'b11110);
    check("s1_no_win_yet", 32'(aif.win), 32'd0);
    do_guess(0, L_E, edges);
    check("s1_mask_e", 32'(aif.found_mask), 32'b11111);
    check("s1_win_edges", 32'(edges), 32'd7);
    check("s1_win", 32'(aif.win), 32'd1);
    check("s1_miss", 32'(aif.miss_count), 32'd0);
    @(posedge clk); #1;
    check("s1_win_held", 32'(aif.win), 32'd1);

    // 2: direct restart from WIN, seven misses to lose.
    do_load(0, W_NOTRE);
    check("s2_restart_win", 32'(aif.win), 32'd0);
    check("s2_restart_mask", 32'(aif.found_mask), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      do_guess(0, L_A, edges);
      check($sformatf("s2_miss_%0d", k), 32'(aif.miss_count), 32'(k));
      check($sformatf("s2_lose_%0d", k), 32'(aif.lose), (k == 7) ? 32'd1 : 32'd0);
    end
    check("s2_mask", 32'(aif.found_mask), 32'd0);
    do_guess(0, L_N, edges);  // LOSE -> IDLE
    check("s2_idle_status",
          32'({aif.busy, aif.found_mask, aif.miss_count, aif.win, aif.lose, aif.repeat_hit}), 32'd0);
    do_guess(0, L_N, edges);  // ignored in IDLE
    check("s2_idle_ignore", 32'(aif.found_mask), 32'd0);

    // 3: duplicate letters and repeat hit.
    do_load(0, W_EERIE);
    do_guess(0, L_E, edges);
    check("s3_mask_e", 32'(aif.found_mask), 32'b11001);
    check("s3_miss", 32'(aif.miss_count), 32'd0);
    check("s3_rh_first", 32'(aif.repeat_hit), 32'd0);
    do_guess(0, L_E, edges);
    check("s3_rh_pulse", 32'(aif.repeat_hit), 32'd1);
    check("s3_miss_again", 32'(aif.miss_count), 32'd0);
    @(posedge clk); #1;
    check("s3_rh_clear", 32'(aif.repeat_hit), 32'd0);
    do_guess(0, L_I, edges);  // still in PLAY: guess is processed
    check("s3_play_i", 32'(aif.found_mask), 32'b11011);

    // 5: asynchronous reset mid-SCAN (idx=2).
    @(negedge clk); aif.guess_valid = 1'b1; aif.guess_letter = L_R;
    @(posedge clk); #1; aif.guess_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("s5_busy_before", 32'(aif.busy), 32'd1);
    reset = 1'b0; #1;
    check("s5_async_status",
          32'({aif.busy, aif.found_mask, aif.miss_count, aif.win, aif.lose, aif.repeat_hit}), 32'd0);
    @(negedge clk) reset = 1'b1;
    do_guess(0, L_E, edges);  // IDLE ignores guesses
    check("s5_idle_ignore", 32'(aif.found_mask), 32'd0);

    // 4: restart after reset, guesses during busy dropped, load ignored in PLAY.
    do_load(0, W_NOTRE);
    @(negedge clk); aif.guess_valid = 1'b1; aif.guess_letter = L_N;
    @(posedge clk); #1;
    edges = 0;
    while (aif.busy && edges < 40) begin
      aif.guess_letter = L_O;
      aif.guess_valid  = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    aif.guess_valid = 1'b0;
    check("s4_busy_edges", 32'(edges), 32'd6);
    check("s4_mask", 32'(aif.found_mask), 32'b10000);
    check("s4_miss", 32'(aif.miss_count), 32'd0);
    aif.word_load = 1'b1; aif.word_in = W_AAAAA[24:0];
    do_guess(0, L_T, edges);
    check("s4_load_guess_t", 32'(aif.found_mask), 32'b10100);
    do_guess(0, L_E, edges);
    check("s4_word_kept", 32'(aif.found_mask), 32'b10101);
    check("s4_miss_kept", 32'(aif.miss_count), 32'd0);

    // 6: WORD_LEN=8, MAX_MISSES=3.
    do_load(1, W_REFEREES);
    do_guess(1, L_E, edges);
    check("s6_mask_e", 32'(bif.found_mask), 32'b01010110);
    check("s6_miss_e", 32'(bif.miss_count), 32'd0);
    do_guess(1, L_E, edges);
    check("s6_rh_pulse", 32'(bif.repeat_hit), 32'd1);
    do_guess(1, L_R, edges); check("s6_mask_r", 32'(bif.found_mask), 32'b11011110);
    do_guess(1, L_F, edges); check("s6_mask_f", 32'(bif.found_mask), 32'b11111110);
    do_guess(1, L_S, edges);
    check("s6_mask_s", 32'(bif.found_mask), 32'hFF);
    check("s6_win_edges", 32'(edges), 32'd10);
    check("s6_win", 32'(bif.win), 32'd1);
    do_load(1, W_REFEREES);
    for (int k = 1; k <= 3; k++) begin
      do_guess(1, L_A, edges);
      check($sformatf("s6_miss_%0d", k), 32'(bif.miss_count), 32'(k));
    end
    check("s6_lose", 32'(bif.lose), 32'd1);
    check("s6_lose_mask", 32'(bif.found_mask), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hangman_engine_param.md
Name: hangman_engine_param

Overview:
- Parametrised successor to the blind-hangman game controller.
- Holds a WORD_LEN-letter secret word, scans each guessed letter against every position (one position per clock) and reveals all matching positions, including duplicate letters.
- Counts misses up to a configurable limit and reports found-mask, miss count and win/lose status.
- Sits between the input decoder (letter + enter strobe) and the output packer that drives the 7-segment/LED status.

Parameters:
- WORD_LEN, 5: letters per secret word (≥1).
- LETTER_W, 5: bits per letter code.
- MAX_MISSES, 7: wrong guesses that end the game as a loss (≥1).
- MISS_W, $clog2(MAX_MISSES+1): width of miss counter (derived; do not override).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- word_load  in  1  load word_in as new secret word (start game).
- word_in  in  WORD_LEN*LETTER_W  secret word; position 0 = MSB slice.
- guess_valid  in  1  single-cycle guess strobe (enter).
- guess_letter  in  LETTER_W  guessed letter code.
- busy  out  1  high while scanning/evaluating; guesses ignored.
- found_mask  out  WORD_LEN  bit WORD_LEN-1-i set when position i is revealed.
- miss_count  out  MISS_W  wrong guesses so far.
- win  out  1  all positions revealed; held until next game.
- lose  out  1  miss_count reached MAX_MISSES; held until next game.
- repeat_hit  out  1  one-cycle pulse at EVAL when a guess matched only already-revealed positions.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, found_mask, miss_count, win, lose and repeat_hit all 0; word register and idx cleared.
- States: IDLE, PLAY, SCAN, EVAL, WIN, LOSE. busy=1 exactly in SCAN and EVAL.
- IDLE:
  - word_load=1 → latch word_in, clear mask and misses, go to PLAY.
  - guess_valid is ignored.
- PLAY:
  - guess_valid=1 → latch guess_letter, idx=0, hit=0, new=0, go to SCAN.
  - word_load is ignored in PLAY. If word_load and guess_valid are asserted together, the guess is taken and the load is dropped.
- SCAN, one position per edge:
  - If word[idx]==letter: set the mask bit and set hit. If that bit was previously clear, also set new.
  - idx increments each edge. After position WORD_LEN-1 → EVAL.
  - SCAN therefore lasts exactly WORD_LEN cycles.
- EVAL, one cycle:
  - If hit=0: miss_count+1.
  - If hit=1 and new=0: repeat_hit pulses; no miss is counted.
  - Next state:
    - mask all ones → WIN (win=1);
    - else updated miss_count==MAX_MISSES → LOSE (lose=1);
    - else PLAY.
- Latency: the guess is accepted at edge E. found_mask and miss_count update at edge E+WORD_LEN (last SCAN) and E+WORD_LEN+1 (EVAL). A new guess is accepted no earlier than edge E+WORD_LEN+2.
- WIN/LOSE (game over):
  - guess_valid=1 → IDLE; all status outputs are cleared.
  - word_load=1 → direct restart into PLAY with the new word and cleared status. If both are asserted, word_load has priority.
- guess_valid while busy is ignored; guesses are not queued.
- miss_count saturates at MAX_MISSES and never wraps.
- Reset asserted mid-SCAN or mid-EVAL aborts immediately to IDLE; no partial update survives.
- Letter code all-zeros is an ordinary letter; there are no reserved codes.

Test Plan:
1. Defaults; load "notre" (01101,01110,10011,10001,00100); guess n,o,t,r,e, each waiting for busy to fall.
   - found_mask after each guess: 10000, 11000, 11100, 11110, 11111.
   - win=1 on the EVAL edge after e, 7 cycles after its accept edge; miss_count=0.
2. Load "notre"; guess 00000 seven times.
   - miss_count steps 1..7; lose=1 after the 7th; found_mask=00000.
   - Then guess_valid → IDLE with all outputs 0.
3. Load "eerie"; guess e.
   - found_mask=11001 in one guess; miss_count=0.
   - Guess e again → repeat_hit pulses one cycle; miss_count stays 0; state PLAY.
4. Load "notre"; guess n, then pulse guess_valid with letter o every cycle during busy.
   - Only the first guess is taken; found_mask=10000; no miss.
   - Assert word_load with a new guess in PLAY → the guess is processed and the word is unchanged.
5. Mid-SCAN (idx=2): assert reset=0 asynchronously.
   - All outputs go to 0 before the next clk edge; state IDLE.
   - After release, word_load restarts cleanly.
6. Override WORD_LEN=8, MAX_MISSES=3 (MISS_W=2).
   - Three misses → lose with miss_count=3.
   - A full correct word → win after 10 cycles per final guess (8 SCAN + EVAL + accept).
   - Re-run scenario 3 at this width.
